// File: rtl/fac_seq_ctrl.sv
// FFT twiddle-multiply sequencer: counts 16-lane beats through a frame, tracks
// downstream credits and tags the fixed-latency datapath output with block/last.
module fac_seq_ctrl #(
  parameter int unsigned FAC_LAT = 1,
  parameter int unsigned BLK_NUM = 32,
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned CREDITS = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [CNT_W-1:0] dp_sel,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_blk,
  output logic             out_last,
  input  logic             cred_ret,
  input  logic             abort,
  output logic             frame_done,
  output logic             busy,
  output logic             cred_err
);

  localparam int unsigned CRW = $clog2(CREDITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] blk_cnt;
  logic [CRW-1:0]   cred_cnt;
  logic             armed;
  logic             accept;
  logic             is_last;
  logic             drained;

  logic [FAC_LAT-1:0] pv;
  logic [FAC_LAT-1:0] pl;
  logic [CNT_W-1:0]   pb [FAC_LAT];

  assign is_last   = (blk_cnt == CNT_W'(BLK_NUM - 1));
  assign in_ready  = rstn && armed && (state != FLUSH) && (cred_cnt != '0) && !abort;
  assign accept    = in_valid && in_ready;
  assign dp_sel    = blk_cnt;
  assign busy      = (state != IDLE);
  assign out_valid = pv[FAC_LAT-1];
  assign out_blk   = pb[FAC_LAT-1];
  assign out_last  = pl[FAC_LAT-1];

  // Nothing enters in FLUSH, so once the stages ahead of the output are empty
  // the pipeline is empty after this edge; finishing here puts frame_done one
  // cycle after the last out_valid.
  always_comb begin
    drained = 1'b1;
    for (int unsigned i = 0; i + 1 < FAC_LAT; i++) begin
      if (pv[i]) drained = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_last ? FLUSH : RUN;
      RUN:     if (accept && is_last) state_nxt = FLUSH;
      FLUSH:   if (drained) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      frame_done <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= (state == FLUSH) && drained && !abort;
      armed      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blk_cnt <= '0;
    end else if (abort) begin
      blk_cnt <= '0;
    end else if (accept) begin
      blk_cnt <= is_last ? '0 : blk_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cred_cnt <= CRW'(CREDITS);
      cred_err <= 1'b0;
    end else if (accept && !cred_ret) begin
      cred_cnt <= cred_cnt - 1'b1;
    end else if (cred_ret && !accept) begin
      if (cred_cnt == CRW'(CREDITS)) cred_err <= 1'b1;
      else                           cred_cnt <= cred_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv <= '0;
      pl <= '0;
      for (int unsigned i = 0; i < FAC_LAT; i++) pb[i] <= '0;
    end else if (abort) begin
      pv <= '0;
      pl <= '0;
      for (int unsigned i = 0; i < FAC_LAT; i++) pb[i] <= '0;
    end else begin
      pv[0] <= accept;
      pl[0] <= accept && is_last;
      pb[0] <= blk_cnt;
      for (int unsigned i = 1; i < FAC_LAT; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
        pb[i] <= pb[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fac_seq_ctrl.sv
// Bench for fac_seq_ctrl: directed frame/credit/abort/reset cases plus random
// traffic, checked against a queue-based model of beats in flight.
module tb_fac_seq_ctrl;
  localparam int FAC_LAT = 1;
  localparam int BLK_NUM = 32;
  localparam int CNT_W   = 5;
  localparam int CREDITS = 4;

  logic clk = 1'b0, rstn = 1'b0, in_valid = 1'b0, cred_ret = 1'b0, abort = 1'b0;
  logic in_ready, out_valid, out_last, frame_done, busy, cred_err;
  logic [CNT_W-1:0] dp_sel, out_blk;

  int checks = 0;
  int errors = 0;

  typedef struct {int due; int blk; bit last;} beat_t;
  beat_t q[$];
  int m_cred, m_blk, ecount;
  bit m_err, m_inframe, m_drain, m_fd, m_armed;

  fac_seq_ctrl #(.FAC_LAT(FAC_LAT), .BLK_NUM(BLK_NUM), .CNT_W(CNT_W), .CREDITS(CREDITS)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .dp_sel(dp_sel),
    .out_valid(out_valid), .out_blk(out_blk), .out_last(out_last), .cred_ret(cred_ret),
    .abort(abort), .frame_done(frame_done), .busy(busy), .cred_err(cred_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cred = CREDITS; m_blk = 0; ecount = 0;
    m_err = 0; m_inframe = 0; m_drain = 0; m_fd = 0; m_armed = 0;
  endtask

  task automatic check_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_blk", out_blk, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_cred_err", cred_err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_dp_sel", dp_sel, 0);
  endtask

  task automatic check_regs();
    bit ev;
    beat_t b;
    ev = (q.size() > 0) && (q[0].due == ecount);
    check("out_valid", out_valid, ev);
    if (ev) begin
      b = q.pop_front();
      check("out_blk", out_blk, b.blk);
      check("out_last", out_last, b.last);
    end else begin
      check("out_last_idle", out_last, 0);
    end
    check("frame_done", frame_done, m_fd);
    check("busy", busy, m_inframe || m_drain);
    check("cred_err", cred_err, m_err);
  endtask

  // One cycle: check registered outputs, drive inputs, check the combinational
  // handshake, advance the model across the edge.
  task automatic step(input bit iv, input bit cr, input bit ab, output bit acc_obs);
    bit rdy, acc, fdn;
    check_regs();
    in_valid = iv; cred_ret = cr; abort = ab;
    #1;
    rdy = m_armed && !m_drain && (m_cred > 0) && !ab;
    check("in_ready", in_ready, rdy);
    check("dp_sel", dp_sel, m_blk);
    acc_obs = iv && in_ready;
    acc = iv && rdy;
    fdn = m_drain && !ab && (q.size() == 0);
    if (acc && !cr) m_cred--;
    else if (cr && !acc) begin
      if (m_cred == CREDITS) m_err = 1;
      else m_cred++;
    end
    if (ab) begin
      q.delete(); m_blk = 0; m_inframe = 0; m_drain = 0;
    end else begin
      if (fdn) m_drain = 0;
      if (acc) begin
        q.push_back('{due: ecount + FAC_LAT, blk: m_blk, last: (m_blk == BLK_NUM - 1)});
        if (m_blk == BLK_NUM - 1) begin
          m_blk = 0; m_inframe = 0; m_drain = 1;
        end else begin
          m_blk++; m_inframe = 1;
        end
      end
    end
    m_fd = fdn;
    m_armed = 1;
    @(posedge clk);
    ecount++;
    @(negedge clk);
  endtask

  initial begin
    bit a;
    int nacc, nfd, nlast;
    model_reset();
    in_valid = 1'b1;
    #2;
    check_reset();
    @(negedge clk);
    rstn = 1'b1;
    model_reset();

    // credit exhaustion, then a single returned credit
    nacc = 0;
    for (int i = 0; i < 8; i++) begin step(1, 0, 0, a); nacc += a; end
    check("exhaust_acc", nacc, 4);
    step(1, 1, 0, a);
    check("exhaust_ready", a, 0);
    nacc = 0;
    for (int i = 0; i < 4; i++) begin step(1, 0, 0, a); nacc += a; end
    check("one_cred_acc", nacc, 1);

    // accept plus cred_ret at two credits leaves two
    step(0, 1, 0, a);
    step(0, 1, 0, a);
    nacc = 0;
    step(1, 1, 0, a); nacc += a;
    for (int i = 0; i < 4; i++) begin step(1, 0, 0, a); nacc += a; end
    check("simul_acc", nacc, 3);

    // abort at block 10
    for (int i = 0; i < 4; i++) step(0, 1, 0, a);
    step(1, 1, 0, a);
    step(1, 1, 0, a);
    check("pre_abort_sel", dp_sel, 10);
    step(1, 0, 1, a);
    check("abort_no_acc", a, 0);
    check("abort_busy", busy, 0);
    check("abort_dp_sel", dp_sel, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, a);
      check("abort_no_done", frame_done, 0);
    end

    // overflow while idle, sticky through a full frame
    step(0, 1, 0, a);
    nacc = 0; nfd = 0; nlast = 0;
    for (int i = 0; i < 40; i++) begin
      step(nacc < BLK_NUM, (i >= 2) && (m_cred < CREDITS), 0, a);
      nacc += a;
      if (frame_done) nfd++;
      if (out_valid && out_last) nlast++;
    end
    check("frame_acc", nacc, BLK_NUM);
    check("frame_done_cnt", nfd, 1);
    check("frame_last_cnt", nlast, 1);
    check("err_sticky", cred_err, 1);

    // reset asserted while flushing
    nacc = 0;
    for (int i = 0; i < 40 && !m_drain; i++) begin
      step(nacc < BLK_NUM, m_cred < CREDITS, 0, a);
      nacc += a;
    end
    check_regs();
    check("flush_busy", busy, 1);
    in_valid = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    check_reset();
    rstn = 1'b1;
    model_reset();
    in_valid = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit cr;
      cr = (m_cred < CREDITS) ? ($urandom_range(2) == 0) : ($urandom_range(63) == 0);
      step($urandom_range(3) != 0, cr, $urandom_range(59) == 0, a);
    end
    check_regs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fac_seq_ctrl.md
FAC_SEQ_CTRL -- requirements
Module: fac_seq_ctrl

Interface
REQ-001 SHALL have parameter FAC_LAT, default 1: fixed latency in cycles of the twiddle-multiply datapath; the datapath has no enable or stall.
REQ-002 SHALL have parameter BLK_NUM, default 32: number of 16-lane beats per FFT frame.
REQ-003 SHALL have parameter CNT_W, default 5: width of the block index, with 2^CNT_W >= BLK_NUM.
REQ-004 SHALL have parameter CREDITS, default 4: depth of the downstream skid buffer.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1: upstream beat available.
REQ-008 SHALL have port in_ready, output, 1: controller accepts a beat this cycle.
REQ-009 SHALL have port dp_sel, output, CNT_W: twiddle-table select for the datapath, valid in the accept cycle.
REQ-010 SHALL have port out_valid, output, 1: datapath output register holds a valid beat.
REQ-011 SHALL have port out_blk, output, CNT_W: block index of the beat flagged by out_valid.
REQ-012 SHALL have port out_last, output, 1: out_valid beat is block BLK_NUM-1.
REQ-013 SHALL have port cred_ret, input, 1: pulse returning one downstream buffer slot.
REQ-014 SHALL have port abort, input, 1: synchronous frame abort.
REQ-015 SHALL have port frame_done, output, 1: one-cycle pulse when a frame has fully drained.
REQ-016 SHALL have port busy, output, 1: high when the state is not IDLE.
REQ-017 SHALL have port cred_err, output, 1: sticky credit-overflow flag.

Function
REQ-018 SHALL implement the states IDLE, RUN and FLUSH.
REQ-019 SHALL define accept as in_valid && in_ready.
REQ-020 SHALL drive in_ready = (state != FLUSH) && (cred_cnt != 0) && !abort, combinationally.
REQ-021 SHALL make the IDLE->RUN transition on an accept; that beat is block 0.
REQ-022 SHALL keep blk_cnt, which increments on each accept and wraps from BLK_NUM-1 to 0; dp_sel = blk_cnt, combinational.
REQ-023 SHALL make the RUN->FLUSH transition on the accept of block BLK_NUM-1; a frame of BLK_NUM=1 goes IDLE->FLUSH directly.
REQ-024 SHALL hold FLUSH until the valid pipeline is empty, then pulse frame_done for one cycle in the same cycle the state returns to IDLE.
REQ-025 SHALL shift a valid/blk/last pipeline of FAC_LAT stages unconditionally every cycle, so out_valid rises exactly FAC_LAT cycles after an accept, carrying that beat's blk_cnt and last flag.
REQ-026 SHALL decrement cred_cnt on accept and increment it on cred_ret; both in the same cycle leave it unchanged.
REQ-027 SHALL treat cred_ret with cred_cnt==CREDITS and no accept as overflow: cred_cnt saturates, cred_err sets, and cred_err stays set until reset.
REQ-028 SHALL, on abort in any state, clear the valid pipeline, set blk_cnt=0 and go to IDLE on the next edge, without a frame_done pulse; cred_cnt is preserved.
REQ-029 SHALL let abort override a simultaneous accept, meaning no beat is taken.
REQ-030 SHALL guarantee out_valid never exceeds the outstanding credits, so the downstream buffer never overflows.

Reset
REQ-031 SHALL, on rstn low, set asynchronously: state=IDLE, blk_cnt=0, cred_cnt=CREDITS, pipeline valids=0, out_valid=0, out_blk=0, out_last=0, frame_done=0, cred_err=0.
REQ-032 SHALL force in_ready=0 while rstn is low.
REQ-033 SHALL release reset synchronously, with no accept in the first cycle after rstn rises.

Verification
REQ-034 SHALL cover the full frame case: with defaults, in_valid held high and cred_ret pulsed every cycle from cycle 2 -> 32 accepts, out_blk 0..31 each 1 cycle after its accept, out_last with blk 31, frame_done 1 cycle after the last out_valid.
REQ-035 SHALL cover credit exhaustion: no cred_ret and in_valid high -> exactly 4 accepts and then in_ready=0; one cred_ret -> exactly one further accept.
REQ-036 SHALL cover simultaneous events: accept together with cred_ret at cred_cnt=2 -> cred_cnt stays 2.
REQ-037 SHALL cover abort: abort at blk_cnt=10 -> state IDLE, no frame_done, and the next accept carries dp_sel=0.
REQ-038 SHALL cover overflow: cred_ret with cred_cnt=4 and idle -> cred_err=1, held through a following full frame, cleared only by rstn.
REQ-039 SHALL cover reset mid-frame: rstn low during FLUSH -> all outputs at their reset values immediately, asynchronously.
